// File: rtl/morse_pkg.sv
// morse_pkg -- shared definitions for the Morse message player.
//   * letter code constants A..H (3-bit codes 0..7)
//   * scheduler state enum (S_WGAP exists only with MORSE_REPEAT_EN)
//   * default symbol/gap unit counts
//   * letter_lookup(): letter code -> {pattern, length}. The pattern is
//     left-aligned and read MSB first; 1 = dash, 0 = dot.
package morse_pkg;

    localparam logic [2:0] L_A = 3'd0;
    localparam logic [2:0] L_B = 3'd1;
    localparam logic [2:0] L_C = 3'd2;
    localparam logic [2:0] L_D = 3'd3;
    localparam logic [2:0] L_E = 3'd4;
    localparam logic [2:0] L_F = 3'd5;
    localparam logic [2:0] L_G = 3'd6;
    localparam logic [2:0] L_H = 3'd7;

    localparam int unsigned DEF_DOT_UNITS  = 1;
    localparam int unsigned DEF_DASH_UNITS = 3;
    localparam int unsigned DEF_SYM_GAP    = 1;
    localparam int unsigned DEF_LTR_GAP    = 3;
    localparam int unsigned DEF_WORD_GAP   = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_MARK,
        S_SGAP,
`ifdef MORSE_REPEAT_EN
        S_LGAP,
        S_WGAP
`else
        S_LGAP
`endif
    } state_t;

    typedef struct packed {
        logic [3:0] pat;
        logic [2:0] len;
    } letter_t;

    function automatic letter_t letter_lookup(input logic [2:0] code);
        letter_t r;
        r = '0;
        case (code)
            L_A:     r = {4'b0100, 3'd2};  // .-
            L_B:     r = {4'b1000, 3'd4};  // -...
            L_C:     r = {4'b1010, 3'd4};  // -.-.
            L_D:     r = {4'b1000, 3'd3};  // -..
            L_E:     r = {4'b0000, 3'd1};  // .
            L_F:     r = {4'b0010, 3'd4};  // ..-.
            L_G:     r = {4'b1100, 3'd3};  // --.
            L_H:     r = {4'b0000, 3'd4};  // ....
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_letter_rom.sv
// morse_letter_rom -- combinational letter code to Morse pattern table.
// Ports:
//   i_letter   in  3  letter code, 0=A .. 7=H
//   o_pattern  out 4  left-aligned symbol pattern, MSB first, 1 = dash
//   o_length   out 3  number of symbols (1..4)
module morse_letter_rom
    import morse_pkg::*;
(
    input  logic [2:0] i_letter,
    output logic [3:0] o_pattern,
    output logic [2:0] o_length
);

    letter_t w_entry;

    always_comb begin
        w_entry = letter_lookup(i_letter);
    end

    assign o_pattern = w_entry.pat;
    assign o_length  = w_entry.len;

endmodule

// File: rtl/morse_msg_scheduler.sv
// morse_msg_scheduler -- buffers up to DEPTH letter codes and plays them as
// tick-timed dot/dash marks on morse_out.
// Optional feature: define MORSE_REPEAT_EN to enable message looping with a
// word gap between passes; otherwise repeat_en is ignored.
// Ports:
//   CLOCK_50     in   system clock
//   key0         in   asynchronous active-low reset
//   tick         in   one-cycle timing unit pulse
//   in_valid     in   letter write request
//   in_letter    in   letter code 0=A .. 7=H
//   in_ready     out  write accepted when high (idle and buffer not full)
//   clear        in   empty the buffer (idle only; beats a same-cycle write)
//   start        in   begin playback (idle only, non-empty message)
//   repeat_en    in   loop the message ("repeat" is a reserved word in SV)
//   busy         out  playback in progress
//   morse_out    out  high during marks
//   letter_done  out  one-cycle pulse at the end of each letter gap
//   msg_done     out  one-cycle pulse at the end of each message pass
//   level        out  number of letters stored
module morse_msg_scheduler
    import morse_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DOT_UNITS  = DEF_DOT_UNITS,
    parameter int unsigned DASH_UNITS = DEF_DASH_UNITS,
    parameter int unsigned SYM_GAP    = DEF_SYM_GAP,
    parameter int unsigned LTR_GAP    = DEF_LTR_GAP,
    parameter int unsigned WORD_GAP   = DEF_WORD_GAP
) (
    input  logic                     CLOCK_50,
    input  logic                     key0,
    input  logic                     tick,
    input  logic                     in_valid,
    input  logic [2:0]               in_letter,
    output logic                     in_ready,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     repeat_en,
    output logic                     busy,
    output logic                     morse_out,
    output logic                     letter_done,
    output logic                     msg_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [2:0] DOT_U  = 3'(DOT_UNITS);
    localparam logic [2:0] DASH_U = 3'(DASH_UNITS);
    localparam logic [2:0] SYM_U  = 3'(SYM_GAP);
    localparam logic [2:0] LTR_U  = 3'(LTR_GAP);
`ifdef MORSE_REPEAT_EN
    localparam logic [2:0] WORD_U = 3'(WORD_GAP);
`endif

    state_t          r_state;
    logic [2:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_play_ptr;
    logic [LW-1:0]   r_level;
    logic [3:0]      r_pat;
    logic [2:0]      r_len;
    logic [2:0]      r_sym_idx;
    logic [2:0]      r_cnt;
    logic            r_entry;
    logic            r_morse;
    logic            r_ldone;
    logic            r_mdone;

    logic [3:0]      w_rom_pat;
    logic [2:0]      w_rom_len;
    logic            w_idle;
    logic            w_clear;
    logic            w_wr;
    logic            w_start;
    logic            w_tick_cnt;
    logic [3:0]      w_shifted;
    logic [2:0]      w_mark_units;
    logic            w_last_sym;
    logic            w_more;
    logic [2:0]      w_cnt_nxt;
`ifndef MORSE_REPEAT_EN
    logic            w_unused_repeat;
    assign w_unused_repeat = repeat_en;
`endif

    morse_letter_rom u_rom (
        .i_letter  (r_mem[r_play_ptr]),
        .o_pattern (w_rom_pat),
        .o_length  (w_rom_len)
    );

    assign w_idle     = (r_state == S_IDLE);
    assign in_ready   = w_idle && (r_level < LW'(DEPTH));
    assign w_clear    = w_idle && clear;
    assign w_wr       = in_valid && in_ready && !clear;
    // A write in the same cycle makes an empty buffer startable.
    assign w_start    = w_idle && start && !clear && ((r_level != '0) || w_wr);
    // The first cycle of a state never counts a tick; ARM handles its own.
    assign w_tick_cnt = tick && !r_entry;
    assign w_shifted  = r_pat << r_sym_idx;
    assign w_mark_units = w_shifted[3] ? DASH_U : DOT_U;
    assign w_last_sym = ((r_sym_idx + 3'd1) == r_len);
    assign w_more     = ((LW'(r_play_ptr) + LW'(1)) < r_level);
    assign w_cnt_nxt  = r_cnt + 3'd1;

    assign busy        = !w_idle;
    assign morse_out   = r_morse;
    assign letter_done = r_ldone;
    assign msg_done    = r_mdone;
    assign level       = r_level;

    always_ff @(posedge CLOCK_50 or negedge key0) begin
        if (!key0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= in_letter;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
            r_level         <= r_level + LW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge key0) begin
        if (!key0) begin
            r_state    <= S_IDLE;
            r_play_ptr <= '0;
            r_pat      <= '0;
            r_len      <= '0;
            r_sym_idx  <= '0;
            r_cnt      <= '0;
            r_entry    <= 1'b0;
            r_morse    <= 1'b0;
            r_ldone    <= 1'b0;
            r_mdone    <= 1'b0;
        end else begin
            r_ldone <= 1'b0;
            r_mdone <= 1'b0;
            r_entry <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_play_ptr <= '0;
                        r_entry    <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_pat     <= w_rom_pat;
                    r_len     <= w_rom_len;
                    r_sym_idx <= '0;
                    r_cnt     <= '0;
                    r_entry   <= 1'b1;
                    r_state   <= S_ARM;
                end
                S_ARM: begin
                    if (tick) begin
                        r_morse <= 1'b1;
                        r_cnt   <= '0;
                        r_entry <= 1'b1;
                        r_state <= S_MARK;
                    end
                end
                S_MARK: begin
                    if (w_tick_cnt) begin
                        if (w_cnt_nxt == w_mark_units) begin
                            r_morse <= 1'b0;
                            r_cnt   <= '0;
                            r_entry <= 1'b1;
                            r_state <= w_last_sym ? S_LGAP : S_SGAP;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                end
                S_SGAP: begin
                    if (w_tick_cnt) begin
                        if (w_cnt_nxt == SYM_U) begin
                            r_sym_idx <= r_sym_idx + 3'd1;
                            r_morse   <= 1'b1;
                            r_cnt     <= '0;
                            r_entry   <= 1'b1;
                            r_state   <= S_MARK;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                end
                S_LGAP: begin
                    if (w_tick_cnt) begin
                        if (w_cnt_nxt == LTR_U) begin
                            r_ldone <= 1'b1;
                            r_cnt   <= '0;
                            r_entry <= 1'b1;
                            if (w_more) begin
                                r_play_ptr <= r_play_ptr + PW'(1);
                                r_state    <= S_LOAD;
                            end else begin
                                r_mdone <= 1'b1;
`ifdef MORSE_REPEAT_EN
                                r_state <= repeat_en ? S_WGAP : S_IDLE;
`else
                                r_state <= S_IDLE;
`endif
                            end
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                end
`ifdef MORSE_REPEAT_EN
                S_WGAP: begin
                    if (w_tick_cnt) begin
                        if (w_cnt_nxt == WORD_U) begin
                            r_play_ptr <= '0;
                            r_cnt      <= '0;
                            r_entry    <= 1'b1;
                            r_state    <= S_LOAD;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_msg_scheduler.sv
module tb_morse_msg_scheduler;

    localparam int unsigned DEPTH = 8;
    localparam int T    = 4;   // clocks per tick
    localparam int DOT  = 1;
    localparam int DASH = 3;
    localparam int SYM  = 1;
    localparam int LTR  = 3;
    localparam int WORD = 7;

    localparam int EV_MARK  = 0;
    localparam int EV_GAP   = 1;
    localparam int EV_LDONE = 2;
    localparam int EV_MDONE = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       key0;
    logic       tick;
    logic       in_valid;
    logic [2:0] in_letter;
    logic       in_ready;
    logic       clear;
    logic       start;
    logic       repeat_en;
    logic       busy;
    logic       morse_out;
    logic       letter_done;
    logic       msg_done;
    logic [3:0] level;

    ev_t   exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    mon_en   = 1'b0;
    int    cyc      = 0;
    string MORSE [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    morse_msg_scheduler #(
        .DEPTH(DEPTH), .DOT_UNITS(DOT), .DASH_UNITS(DASH),
        .SYM_GAP(SYM), .LTR_GAP(LTR), .WORD_GAP(WORD)
    ) dut (
        .CLOCK_50(clk), .key0(key0), .tick(tick), .in_valid(in_valid),
        .in_letter(in_letter), .in_ready(in_ready), .clear(clear),
        .start(start), .repeat_en(repeat_en), .busy(busy),
        .morse_out(morse_out), .letter_done(letter_done),
        .msg_done(msg_done), .level(level)
    );

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    function automatic string ev_name(input int k);
        case (k)
            EV_MARK:  return "mark_len";
            EV_GAP:   return "gap_len";
            EV_LDONE: return "letter_done_delay";
            default:  return "msg_done_delay";
        endcase
    endfunction

    task automatic push_ev(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Expected event stream for a message, built from the dot/dash strings.
    task automatic push_msg(input int letters[8], input int n, input int passes);
        int gap;
        bit first;
        string s;
        first = 1'b1;
        gap = 0;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < n; i++) begin
                s = MORSE[letters[i]];
                for (int j = 0; j < s.len(); j++) begin
                    if (!first) push_ev(EV_GAP, gap);
                    first = 1'b0;
                    push_ev(EV_MARK, (s.getc(j) == "-") ? DASH * T : DOT * T);
                    gap = SYM * T;
                end
                push_ev(EV_LDONE, LTR * T);
                gap = LTR * T + T;
            end
            push_ev(EV_MDONE, 0);
            gap = LTR * T + WORD * T + T;
        end
    endtask

    // Monitor: turns DUT output activity into events and checks them in order.
    initial begin : monitor
        bit   prev_m;
        bit   fall_v;
        int   rise_c, fall_c, ld_c;
        ev_t  obs[$];
        ev_t  o, e;
        prev_m = 1'b0; fall_v = 1'b0; rise_c = 0; fall_c = 0; ld_c = 0;
        forever begin
            @(negedge clk);
            cyc++;
            obs.delete();
            if (mon_en) begin
                if (morse_out && !prev_m) begin
                    rise_c = cyc;
                    if (fall_v) begin
                        o.kind = EV_GAP; o.val = cyc - fall_c; obs.push_back(o);
                    end
                end
                if (!morse_out && prev_m) begin
                    o.kind = EV_MARK; o.val = cyc - rise_c; obs.push_back(o);
                    fall_c = cyc;
                    fall_v = 1'b1;
                end
                if (letter_done) begin
                    o.kind = EV_LDONE; o.val = cyc - fall_c; obs.push_back(o);
                    ld_c = cyc;
                end
                if (msg_done) begin
                    o.kind = EV_MDONE; o.val = cyc - ld_c; obs.push_back(o);
                end
            end
            if (!busy || !mon_en) fall_v = 1'b0;
            prev_m = morse_out;
            foreach (obs[k]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL monitor: unexpected %s=%0d at cycle %0d, required no event",
                             ev_name(obs[k].kind), obs[k].val, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (obs[k].kind !== e.kind || obs[k].val !== e.val) begin
                        n_errors++;
                        $display("FAIL monitor: got %s=%0d at cycle %0d, required %s=%0d",
                                 ev_name(obs[k].kind), obs[k].val, cyc, ev_name(e.kind), e.val);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic write_letter(input logic [2:0] l);
        in_valid = 1'b1;
        in_letter = l;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        key0 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (level !== 4'd0)     begin n_errors++; $display("FAIL reset_level: got %0d, required 0", level); end
        if (busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (morse_out !== 1'b0) begin n_errors++; $display("FAIL reset_morse: got %b, required 0", morse_out); end
        if (letter_done !== 1'b0) begin n_errors++; $display("FAIL reset_ldone: got %b, required 0", letter_done); end
        if (msg_done !== 1'b0)  begin n_errors++; $display("FAIL reset_mdone: got %b, required 0", msg_done); end
        if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        key0 = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_letter_e();
        int  msg[8];
        bit  seen, ok;
        msg = '{4, 0, 0, 0, 0, 0, 0, 0};
        push_msg(msg, 1, 1);
        // Write and start in the same cycle on an empty buffer.
        in_valid = 1'b1; in_letter = 3'd4; start = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (msg_done) begin seen = 1'b1; break; end
        end
        n_checks += 2;
        if (!seen) begin n_errors++; $display("FAIL e_msg_done: got no pulse in 200 clocks, required pulse"); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL e_busy_at_done: got %b, required 0", busy); end
        wait_drain(500, ok);
        n_checks += 2;
        if (!ok) begin n_errors++; $display("FAIL e_drain: %0d events left, required 0", exp_q.size()); end
        if (level !== 4'd1) begin n_errors++; $display("FAIL e_level_kept: got %0d, required 1", level); end
        pulse_clear();
    endtask

    task automatic test_letter_a();
        int msg[8];
        bit ok;
        msg = '{0, 0, 0, 0, 0, 0, 0, 0};
        write_letter(3'd0);
        push_msg(msg, 1, 1);
        pulse_start();
        wait_drain(500, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL a_drain: %0d events left, required 0", exp_q.size()); end
        pulse_clear();
    endtask

    task automatic test_full_buffer();
        for (int i = 0; i < 8; i++) write_letter(3'(i));
        n_checks += 2;
        if (level !== 4'd8)    begin n_errors++; $display("FAIL full_level: got %0d, required 8", level); end
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_in_ready: got %b, required 0", in_ready); end
        write_letter(3'd2);
        n_checks++;
        if (level !== 4'd8) begin n_errors++; $display("FAIL full_overflow_level: got %0d, required 8", level); end
        pulse_clear();
        n_checks += 2;
        if (level !== 4'd0)    begin n_errors++; $display("FAIL full_clear_level: got %0d, required 0", level); end
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL full_clear_ready: got %b, required 1", in_ready); end
        write_letter(3'd1);
        in_valid = 1'b1; in_letter = 3'd3; clear = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        n_checks++;
        if (level !== 4'd0) begin n_errors++; $display("FAIL clear_beats_write: got %0d, required 0", level); end
    endtask

    task automatic test_back_to_back();
        int msg[8];
        bit ok;
        msg = '{1, 2, 0, 0, 0, 0, 0, 0};
        write_letter(3'd1);
        write_letter(3'd2);
        push_msg(msg, 2, 1);
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1; clear = 1'b1; in_valid = 1'b1; in_letter = 3'd7;
        @(negedge clk);
        start = 1'b0; clear = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (level !== 4'd2) begin n_errors++; $display("FAIL busy_ignore_level: got %0d, required 2", level); end
        wait_drain(1000, ok);
        n_checks += 2;
        if (!ok) begin n_errors++; $display("FAIL bc_drain: %0d events left, required 0", exp_q.size()); end
        if (level !== 4'd2) begin n_errors++; $display("FAIL bc_level_end: got %0d, required 2", level); end
        pulse_clear();
    endtask

    task automatic test_reset_mid_dash();
        bit rose, stayed_idle;
        mon_en = 1'b0;
        write_letter(3'd3);
        pulse_start();
        rose = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (morse_out) begin rose = 1'b1; break; end
        end
        repeat (5) @(negedge clk);
        #1 key0 = 1'b0;
        #1;
        n_checks += 4;
        if (!rose) begin n_errors++; $display("FAIL d_mark_start: got no mark in 100 clocks, required mark"); end
        if (morse_out !== 1'b0) begin n_errors++; $display("FAIL async_morse: got %b, required 0", morse_out); end
        if (busy !== 1'b0)      begin n_errors++; $display("FAIL async_busy: got %b, required 0", busy); end
        if (level !== 4'd0)     begin n_errors++; $display("FAIL async_level: got %0d, required 0", level); end
        @(negedge clk);
        key0 = 1'b1;
        @(negedge clk);
        pulse_start();
        stayed_idle = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) stayed_idle = 1'b0;
        end
        n_checks += 2;
        if (!stayed_idle)   begin n_errors++; $display("FAIL empty_start_busy: got busy=1, required 0"); end
        if (level !== 4'd0) begin n_errors++; $display("FAIL post_reset_level: got %0d, required 0", level); end
        mon_en = 1'b1;
    endtask

    task automatic test_repeat();
        int msg[8];
        bit ok, reached;
        msg = '{4, 0, 0, 0, 0, 0, 0, 0};
        write_letter(3'd4);
        repeat_en = 1'b1;
`ifdef MORSE_REPEAT_EN
        push_msg(msg, 1, 2);
        pulse_start();
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() <= 3) begin reached = 1'b1; break; end
        end
        repeat_en = 1'b0;
        n_checks++;
        if (!reached) begin n_errors++; $display("FAIL rpt_second_pass: %0d events left, required <=3", exp_q.size()); end
`else
        reached = 1'b1;
        push_msg(msg, 1, 1);
        pulse_start();
`endif
        wait_drain(1000, ok);
        repeat_en = 1'b0;
        n_checks += 2;
        if (!ok) begin n_errors++; $display("FAIL rpt_drain: %0d events left, required 0", exp_q.size()); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL rpt_end_busy: got %b, required 0", busy); end
        pulse_clear();
    endtask

    initial begin
        key0 = 1'b0; in_valid = 1'b0; in_letter = '0;
        clear = 1'b0; start = 1'b0; repeat_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_letter_e();
        test_letter_a();
        test_full_buffer();
        test_back_to_back();
        test_reset_mid_dash();
        test_repeat();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL final_queue: got %0d pending events, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
